// File: rtl/riscv_ifu.sv
// rtl/riscv_ifu.sv - instruction fetch unit: PC, single-outstanding fetch, decode handoff, redirect/fault handling
module riscv_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic                  mem_rsp_err,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [6:0]            id_opcode,
    output logic                  id_fault
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, KILL, HOLD, HALT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] rpc;

    assign rpc           = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = pc;
    assign id_valid      = (state == HOLD);
    assign id_opcode     = id_instr[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            id_pc    <= '0;
            id_instr <= '0;
            id_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    // An accepted request that is redirected still owes us a response.
                    if (redirect_valid) pc <= rpc;
                    if (mem_req_ready) state <= redirect_valid ? KILL : WAIT;
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (redirect_valid) begin
                            pc    <= rpc;
                            state <= REQ;
                        end else begin
                            id_instr <= mem_rsp_data;
                            id_pc    <= pc;
                            id_fault <= mem_rsp_err;
                            pc       <= pc + ADDR_WIDTH'(4);
                            state    <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc    <= rpc;
                        state <= KILL;
                    end
                end
                KILL: begin
                    if (redirect_valid) pc <= rpc;
                    if (mem_rsp_valid) state <= REQ;
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= rpc;
                        state <= REQ;
                    end else if (id_ready) begin
                        state <= id_fault ? HALT : REQ;
                    end
                end
                HALT: begin
                    if (redirect_valid) begin
                        pc    <= rpc;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
